// File: rtl/cacheline_adaptor.sv
// Cache-line to memory-burst adaptor: serves one line read or write from the cache
// as BEATS back-to-back (stallable) beats on the memory burst interface.
module cacheline_adaptor #(
  parameter int unsigned BURST_W = 64,
  parameter int unsigned BEATS   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BURST_W*BEATS-1:0]   line_i,
  output logic [BURST_W*BEATS-1:0]   line_o,
  input  logic [31:0]                address_i,
  input  logic                       read_i,
  input  logic                       write_i,
  output logic                       resp_o,
  input  logic [BURST_W-1:0]         burst_i,
  output logic [BURST_W-1:0]         burst_o,
  output logic [31:0]                address_o,
  output logic                       read_o,
  output logic                       write_o,
  input  logic                       resp_i
);

  localparam int unsigned LINE_W = BURST_W * BEATS;
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  // Byte-offset bits within a line are forced to zero on the memory side.
  localparam logic [31:0] OFFSET_MASK = 32'(LINE_W / 8 - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr,
    StDone
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [LINE_W-1:0]  line_q;
  logic [31:0]        addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (write_i) begin
            line_q  <= line_i;
            addr_q  <= address_i & ~OFFSET_MASK;
            cnt_q   <= '0;
            state_q <= StWr;
          end else if (read_i) begin
            addr_q  <= address_i & ~OFFSET_MASK;
            cnt_q   <= '0;
            state_q <= StRd;
          end
        end
        StRd: begin
          if (resp_i) begin
            line_q[32'(cnt_q) * BURST_W +: BURST_W] <= burst_i;
            cnt_q <= (cnt_q == LAST_BEAT) ? '0 : cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BEAT) state_q <= StDone;
          end
        end
        StWr: begin
          if (resp_i) begin
            cnt_q <= (cnt_q == LAST_BEAT) ? '0 : cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BEAT) state_q <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Everything below is a pure decode of registered state.
  assign read_o    = (state_q == StRd);
  assign write_o   = (state_q == StWr);
  assign resp_o    = (state_q == StDone);
  assign address_o = addr_q;
  assign line_o    = line_q;
  assign burst_o   = line_q[32'(cnt_q) * BURST_W +: BURST_W];

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: a beat-level memory model answers bursts,
// a line-level reference predicts every line response.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cacheline_adaptor #(
    .BURST_W(64),
    .BEATS  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .line_i   (line_i),
    .line_o   (line_o),
    .address_i(address_i),
    .read_i   (read_i),
    .write_i  (write_i),
    .resp_o   (resp_o),
    .burst_i  (burst_i),
    .burst_o  (burst_o),
    .address_o(address_o),
    .read_o   (read_o),
    .write_o  (write_o),
    .resp_i   (resp_i)
  );

  typedef struct {
    bit           is_write;
    logic [31:0]  addr;
    logic [255:0] line;
  } txn_t;

  txn_t         exp_q[$];
  logic [63:0]  mem[logic [31:0]];
  logic [255:0] ref_lines[logic [31:0]];
  bit           pat_q[$];
  bit           mem_always = 1'b0;
  int unsigned  xfers = 0;
  int           checks = 0;
  int           failures = 0;

  function automatic logic [63:0] init_beat(logic [31:0] key);
    return {key, key ^ 32'hA5A5_5A5A};
  endfunction

  function automatic logic [63:0] mem_rd(logic [31:0] key);
    return mem.exists(key) ? mem[key] : init_beat(key);
  endfunction

  // Line-level view: last line written, else the memory's power-up contents.
  function automatic logic [255:0] ref_line(logic [31:0] a);
    logic [255:0] l;
    if (ref_lines.exists(a)) return ref_lines[a];
    for (int b = 0; b < 4; b++) l[b*64 +: 64] = init_beat(a + 32'(b * 8));
    return l;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: one decision per cycle, 1 time unit after the edge.
  initial begin
    int beat;
    logic [31:0] key;
    beat    = 0;
    resp_i  = 1'b0;
    burst_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        beat   = 0;
        resp_i = 1'b0;
      end else if (read_o || write_o) begin
        if (pat_q.size() > 0) resp_i = pat_q.pop_front();
        else if (mem_always) resp_i = 1'b1;
        else resp_i = ($urandom_range(0, 2) != 0);
        if (resp_i) begin
          key = address_o + 32'(beat * 8);
          if (write_o) mem[key] = burst_o;
          else burst_i = mem_rd(key);
          beat = (beat + 1) % 4;
          xfers++;
        end else if (read_o) begin
          burst_i = {$urandom(), $urandom()};
        end
      end else begin
        resp_i  = ($urandom_range(0, 3) == 0);
        burst_i = {$urandom(), $urandom()};
      end
    end
  end

  // Monitor: checks burst-side activity against the pending request and pops on resp_o.
  initial begin
    bit   prev;
    txn_t e;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (read_o || write_o) begin
          if (exp_q.size() == 0) begin
            chk("burst_without_request", {read_o, write_o}, 0);
          end else begin
            chk("address_o", address_o, exp_q[0].addr);
            chk("burst_dir", {read_o, write_o}, exp_q[0].is_write ? 2'b01 : 2'b10);
          end
        end
        if (resp_o) begin
          chk("resp_pulse_width", prev, 0);
          if (exp_q.size() == 0) begin
            chk("unexpected_resp", resp_o, 0);
          end else begin
            e = exp_q.pop_front();
            chk(e.is_write ? "wr_line_o" : "rd_line_o", line_o, e.line);
            if (e.is_write)
              chk("mem_after_write", {mem_rd(e.addr + 24), mem_rd(e.addr + 16),
                                      mem_rd(e.addr + 8), mem_rd(e.addr)}, e.line);
          end
        end
        prev = resp_o;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [255:0] line, input int exp_lat);
    txn_t        e;
    int unsigned t0;
    bit          got;
    e.is_write = wr;
    e.addr     = addr & ~32'h1F;
    if (wr) begin
      ref_lines[e.addr] = line;
      e.line = line;
    end else begin
      e.line = ref_line(e.addr);
    end
    exp_q.push_back(e);
    read_i    = rd;
    write_i   = wr;
    address_i = addr;
    line_i    = line;
    t0        = cyc;
    got       = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      tick();
      if (resp_o) got = 1'b1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL resp_timeout: got no resp_o, required one within 300 cycles");
      rst = 1'b1;
      read_i  = 1'b0;
      write_i = 1'b0;
      tick();
      exp_q.delete();
      rst = 1'b0;
    end else begin
      if (exp_lat > 0) chk("latency", 256'(cyc - t0), 256'(exp_lat));
      tick();
      read_i    = 1'b0;
      write_i   = 1'b0;
      address_i = $urandom();
      line_i    = {8{$urandom()}};
    end
  endtask

  task automatic gap();
    repeat (1 + $urandom_range(0, 2)) tick();
  endtask

  initial begin
    logic [255:0] l;
    logic [3:0]   nib;
    txn_t         e;
    bit           wr;
    bit           rd;
    logic [31:0]  a;
    int unsigned  x0;

    rst       = 1'b1;
    read_i    = 1'b0;
    write_i   = 1'b0;
    address_i = '0;
    line_i    = '0;
    repeat (2) tick();
    chk("rst_line_o", line_o, 0);
    chk("rst_read_o", read_o, 0);
    chk("rst_write_o", write_o, 0);
    chk("rst_resp_o", resp_o, 0);
    chk("rst_address_o", address_o, 0);
    chk("rst_burst_o", burst_o, 0);
    rst = 1'b0;
    tick();

    // Directed read, back-to-back beats 0x11.., 0x22.., 0x33.., 0x44..
    for (int b = 0; b < 4; b++) begin
      nib = 4'(b + 1);
      mem[32'h1220 + 32'(b * 8)] = {16{nib}};
    end
    ref_lines[32'h1220] = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    mem_always = 1'b1;
    do_txn(1'b1, 1'b0, 32'h0000_1234, {8{$urandom()}}, 5);
    mem_always = 1'b0;
    gap();

    // Directed write with stall pattern 1,0,1,0,0,1,1
    pat_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    l = {64'hD3D3_0000_3333_D3D3, 64'hD2D2_0000_2222_D2D2,
         64'hD1D1_0000_1111_D1D1, 64'hD0D0_0000_0000_D0D0};
    do_txn(1'b0, 1'b1, 32'h8000_00E0, l, 8);
    gap();

    // Simultaneous read and write: write must win
    do_txn(1'b1, 1'b1, 32'h0000_2040, {8{$urandom()}}, 0);
    gap();
    do_txn(1'b1, 1'b0, 32'h8000_00E7, {8{$urandom()}}, 0);
    gap();

    // Reset after two of four read beats
    mem_always = 1'b1;
    e.is_write = 1'b0;
    e.addr     = 32'h0000_4040;
    e.line     = ref_line(32'h0000_4040);
    exp_q.push_back(e);
    x0        = xfers;
    read_i    = 1'b1;
    address_i = 32'h0000_4040;
    for (int i = 0; i < 20 && xfers < x0 + 2; i++) tick();
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_line_o", line_o, 0);
    chk("midrst_read_o", read_o, 0);
    chk("midrst_write_o", write_o, 0);
    chk("midrst_resp_o", resp_o, 0);
    chk("midrst_address_o", address_o, 0);
    chk("midrst_burst_o", burst_o, 0);
    read_i = 1'b0;
    exp_q.delete();
    tick();
    rst = 1'b0;
    repeat (8) tick();
    do_txn(1'b1, 1'b0, 32'h0000_4040, {8{$urandom()}}, 5);
    mem_always = 1'b0;
    gap();

    // Randomized traffic over a small set of lines so reads hit earlier writes
    for (int n = 0; n < 150; n++) begin
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      a  = 32'h0001_0000 | (32'($urandom_range(0, 7)) << 5) | 32'($urandom_range(0, 31));
      l  = {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
      do_txn(rd, wr, a, l, 0);
      gap();
    end

    repeat (5) tick();
    chk("queue_drained", 256'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Responder end of the cache's physical-memory line interface.
- Accepts one 256-bit line read or write request from the cache (pmem_read/pmem_write, pmem_address, pmem_wdata).
- Executes the request as a burst of four 64-bit beats on the main-memory burst interface.
- Returns a single-cycle line response (pmem_resp, pmem_rdata) to the cache.

Parameters:
- BURST_W, 64, width of one memory beat in bits.
- BEATS, 4, beats per line; line width = BURST_W*BEATS = 256.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- line_i  input  256  write line from cache (pmem_wdata).
- line_o  output  256  read line to cache (pmem_rdata).
- address_i  input  32  line address from cache (pmem_address).
- read_i  input  1  line read request (pmem_read).
- write_i  input  1  line write request (pmem_write).
- resp_o  output  1  line done (pmem_resp), one-cycle pulse.
- burst_i  input  64  read beat from memory.
- burst_o  output  64  write beat to memory.
- address_o  output  32  burst address to memory.
- read_o  output  1  burst read request.
- write_o  output  1  burst write request.
- resp_i  input  1  memory beat strobe; one beat transferred per cycle high.

Behaviour:
- States: IDLE, RD, WR, DONE. 2-bit beat counter, 256-bit line register, 32-bit address register. All outputs are driven from registers or state.
- Reset (async, any state): state=IDLE, counter=0, line register=0, address register=0.
  - Outputs at reset: read_o=0, write_o=0, resp_o=0, address_o=0, burst_o=0, line_o=0.
  - A burst in flight is abandoned and no resp_o is produced.
- IDLE:
  - write_i=1: latch line_i and address_i with bits [4:0] forced to 0, counter=0, go to WR.
  - Else read_i=1: latch address_i the same way, counter=0, go to RD.
  - Write has priority if both requests are high.
  - resp_i is ignored in IDLE.
- RD:
  - read_o=1 and address_o=latched address for the whole state.
  - Each cycle with resp_i=1: burst_i is stored into line bits [64*k+63:64*k], k=counter, then the counter increments.
  - When the beat with counter=3 is captured, go to DONE. read_o drops in the DONE cycle.
- WR:
  - write_o=1 and address_o=latched address for the whole state.
  - burst_o = line register bits [64*k+63:64*k], k=counter; beat 0 is presented in the first WR cycle.
  - Each cycle with resp_i=1 increments the counter. Beat with counter=3 accepted -> DONE.
- DONE:
  - resp_o=1 for exactly one cycle.
  - line_o = assembled line (read) or unchanged write data (write); line_o holds the register value in all states.
  - Next state is IDLE.
- Counter wraps 3->0 on the final beat. Beats are never dropped: resp_i stalls are allowed between beats, and the state holds.
- Latency:
  - Request sampled at edge 0; read_o/write_o high from cycle 1.
  - With resp_i high on cycles 1..4, resp_o is high in cycle 5.
  - Minimum request-to-response is 5 cycles.
- Requester rules:
  - Hold read_i/write_i and line_i/address_i stable until resp_o.
  - Deassert request(s) in the cycle following resp_o.
  - Changes to request inputs during RD/WR/DONE are ignored.
- resp_i high outside RD/WR, or a fifth beat, has no effect.

Test Plan:
- Reset mid-read: assert rst after 2 of 4 beats, then release -> all outputs 0, state IDLE, no resp_o ever seen; next read completes normally.
- Line read, back-to-back beats:
  - Stimulus: read_i=1, address_i=0x0000_1234; resp_i high 4 cycles with burst_i = 0x11..11, 0x22..22, 0x33..33, 0x44..44.
  - Response: address_o=0x0000_1220, read_o high exactly 4 cycles, resp_o one pulse in cycle 5, line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Line write with stalls:
  - Stimulus: write_i=1, line_i = {D3,D2,D1,D0}, address_i=0x8000_00E0; resp_i pattern 1,0,1,0,0,1,1.
  - Response: burst_o = D0, D1, D2, D3 in order, each held until its resp_i; write_o high 7 cycles; resp_o one cycle after the last beat.
- Simultaneous request: read_i=1 and write_i=1 in IDLE -> WR entered, write_o=1, read_o stays 0.
- Back-to-back: read completes, requester drops read_i after resp_o, then issues write_i next cycle -> write starts from IDLE with counter=0; resp_i in the gap ignored.
